hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rstn  input  1  asynchronous active-low reset.
REQ-003 rs1_id, rs2_id  input  5 each  source register indices of the instruction in ID.
REQ-004 rs1_used_id, rs2_used_id  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-005 rd_ex  input  5  destination index of the instruction in EX.
REQ-006 mem_read_ex  input  1  EX instruction is a load.
REQ-007 branch_taken_ex  input  1  one-cycle pulse: EX resolved a taken branch or jump.
REQ-008 target_ex  input  32  redirect target, valid with branch_taken_ex.
REQ-009 dmem_busy  input  1  data memory not ready; MEM stage must hold.
REQ-010 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  output  1 each  hold the named register.
REQ-011 bubble_id_ex, bubble_mem_wb  output  1 each  load a NOP into the named register.
REQ-012 flush_if_id  output  1  squash the IF/ID contents.
REQ-013 pc_redirect  output  1  one-cycle pulse: load the PC from pc_target.
REQ-014 pc_target  output  32  redirect address.
REQ-015 stall_cycles  output  32  saturating count of MEM_WAIT cycles (HAZARD_PERF_EN only).
REQ-016 flush_count  output  16  saturating count of redirects (HAZARD_PERF_EN only).

Function
REQ-017 The block SHALL implement two states: RUN and MEM_WAIT. It SHALL also hold one pending-redirect register made of a valid bit and a 32-bit target.
REQ-018 Load-use is defined as mem_read_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
REQ-019 In RUN with load-use, and with no redirect or dmem_busy, the block SHALL assert stall_pc, stall_if_id and bubble_id_ex combinationally for that cycle only. The stall lasts exactly 1 cycle; the dependency is then resolved by WB forwarding.
REQ-020 In RUN with branch_taken_ex and !dmem_busy, the block SHALL assert pc_redirect, flush_if_id and bubble_id_ex in the same cycle, with pc_target = target_ex.
REQ-021 Redirect SHALL take priority over load-use. When both occur, the block SHALL NOT assert stall_pc or stall_if_id.
REQ-022 In RUN with dmem_busy, the block SHALL go to MEM_WAIT on the next edge. The detection cycle itself SHALL already behave as MEM_WAIT per REQ-023.
REQ-023 In MEM_WAIT, or in RUN with dmem_busy, the block SHALL:
- assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and bubble_mem_wb;
- keep flush_if_id, bubble_id_ex and pc_redirect deasserted.
REQ-024 If branch_taken_ex occurs while dmem_busy is high (either state), the block SHALL latch target_ex into the pending register.
REQ-025 In MEM_WAIT with !dmem_busy, the block SHALL return to RUN on the next edge. Pipeline holds SHALL release in that same cycle.
REQ-026 If pending is valid in that exit cycle, the block SHALL:
- assert pc_redirect, flush_if_id and bubble_id_ex, with pc_target = pending target;
- clear pending on that edge;
- suppress load-use stall signals in that cycle.
REQ-027 A second branch_taken_ex while pending is already valid SHALL overwrite the stored target (last wins).
REQ-028 dmem_busy asserted for exactly 1 cycle SHALL produce exactly 1 held cycle.
REQ-029 All hold, bubble, flush and redirect outputs SHALL be combinational from state, pending and inputs. There is no added latency.

Reset
REQ-030 Asserting rstn low SHALL asynchronously force:
- state to RUN;
- pending valid to 0 and pending target to 0;
- stall_cycles and flush_count to 0.
REQ-031 During reset, all 1-bit outputs SHALL be 0 and pc_target SHALL be 0. Reset asserted in MEM_WAIT SHALL discard any pending redirect.

Configuration
REQ-032 With HAZARD_PERF_EN defined, the block SHALL implement both counters:
- stall_cycles increments each cycle the REQ-023 holds are active;
- flush_count increments on each pc_redirect;
- both counters saturate at all-ones.
REQ-033 Without HAZARD_PERF_EN, stall_cycles and flush_count SHALL still be present as ports, SHALL be tied to 0, and SHALL have no registers.

Structure
REQ-034 The shared defines header SHALL hold the state encodings HZ_RUN=1'b0 and HZ_MEM_WAIT=1'b1, and the NOP-bubble constant.
REQ-035 Load-use detection SHALL be one sub-module, load_use_detect (combinational). Everything else SHALL stay in hazard_ctrl.

Verification
REQ-036 mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> stall_pc=stall_if_id=bubble_id_ex=1 for 1 cycle. With rd_ex=0 -> no stall.
REQ-037 branch_taken_ex pulse, target_ex=0x0000_1040 -> pc_redirect=1, flush_if_id=1, pc_target=0x1040 in the same cycle. A simultaneous load-use gives no stall_pc.
REQ-038 dmem_busy high for 3 cycles -> all four stalls plus bubble_mem_wb high for exactly 3 cycles. stall_cycles goes 0->3 with HAZARD_PERF_EN.
REQ-039 branch_taken_ex (target 0x2000) in the 2nd busy cycle, then 0x3000 in the 3rd -> exactly one pc_redirect, with pc_target=0x3000, in the first non-busy cycle; flush_count=1.
REQ-040 rstn low during MEM_WAIT with pending valid -> outputs 0 immediately, no redirect after release, state RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared definitions for the pipeline hazard controller
//
// Contents:
//   hz_state_e    : controller state encoding (HZ_RUN / HZ_MEM_WAIT)
//   HZ_NOP_INSTR  : instruction word loaded into a register when it is bubbled
//   hz_sat_inc_32 : saturating increment for 32-bit counters
//   hz_sat_inc_16 : saturating increment for 16-bit counters
package hazard_ctrl_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] HZ_NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] hz_sat_inc_32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] hz_sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// rtl/hazard_ctrl_load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   i_rs1_id, i_rs2_id           : source register indices of the ID instruction
//   i_rs1_used_id, i_rs2_used_id : ID instruction actually reads that source
//   i_rd_ex                      : destination index of the EX instruction
//   i_mem_read_ex                : EX instruction is a load
//   o_load_use                   : ID needs a value the EX load has not produced yet
module load_use_detect (
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_rs1_used_id,
  input  logic       i_rs2_used_id,
  input  logic [4:0] i_rd_ex,
  input  logic       i_mem_read_ex,
  output logic       o_load_use
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never written, so a load to x0 cannot create a dependency.
  assign w_rd_nonzero = (i_rd_ex != 5'd0);
  assign w_rs1_hit    = i_rs1_used_id && (i_rs1_id == i_rd_ex);
  assign w_rs2_hit    = i_rs2_used_id && (i_rs2_id == i_rd_ex);
  assign o_load_use   = i_mem_read_ex && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall / flush / redirect controller
//
// Ports:
//   clk, rstn                     : clock, asynchronous active-low reset
//   rs1_id, rs2_id, rs*_used_id   : ID-stage source operands
//   rd_ex, mem_read_ex            : EX-stage destination and load flag
//   branch_taken_ex, target_ex    : EX-stage taken branch pulse and target
//   dmem_busy                     : data memory not ready, MEM must hold
//   stall_pc .. stall_ex_mem      : hold the named pipeline register
//   bubble_id_ex, bubble_mem_wb   : load a NOP into the named register
//   flush_if_id                   : squash IF/ID
//   pc_redirect, pc_target        : one-cycle PC load and its address
//   stall_cycles, flush_count     : saturating performance counters
//
// Optional feature macro: HAZARD_PERF_EN (counters implemented; tied to 0 otherwise).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        branch_taken_ex,
  input  logic [31:0] target_ex,
  input  logic        dmem_busy,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        bubble_id_ex,
  output logic        bubble_mem_wb,
  output logic        flush_if_id,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  hz_state_e   r_state;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic w_load_use;
  logic w_hold;
  logic w_exit;
  logic w_pend_redirect;
  logic w_redirect;
  logic w_lu_stall;

  load_use_detect u_load_use_detect (
    .i_rs1_id      (rs1_id),
    .i_rs2_id      (rs2_id),
    .i_rs1_used_id (rs1_used_id),
    .i_rs2_used_id (rs2_used_id),
    .i_rd_ex       (rd_ex),
    .i_mem_read_ex (mem_read_ex),
    .o_load_use    (w_load_use)
  );

  // The cycle that first sees dmem_busy already holds the pipe, and the
  // MEM_WAIT cycle that sees it drop already releases, so the hold is
  // exactly the busy input in either state.
  assign w_hold          = dmem_busy;
  assign w_exit          = (r_state == HZ_MEM_WAIT) && !dmem_busy;
  assign w_pend_redirect = w_exit && r_pend_valid;
  assign w_redirect      = !w_hold && (branch_taken_ex || w_pend_redirect);
  assign w_lu_stall      = !w_hold && !w_redirect && w_load_use;

  // Every output is forced low while reset is asserted.
  assign stall_pc      = rstn && (w_hold || w_lu_stall);
  assign stall_if_id   = rstn && (w_hold || w_lu_stall);
  assign stall_id_ex   = rstn && w_hold;
  assign stall_ex_mem  = rstn && w_hold;
  assign bubble_mem_wb = rstn && w_hold;
  assign bubble_id_ex  = rstn && (w_redirect || w_lu_stall);
  assign flush_if_id   = rstn && w_redirect;
  assign pc_redirect   = rstn && w_redirect;
  assign pc_target     = !rstn          ? 32'd0 :
                         w_pend_redirect ? r_pend_target : target_ex;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= HZ_RUN;
    end else begin
      case (r_state)
        HZ_RUN:      r_state <= dmem_busy ? HZ_MEM_WAIT : HZ_RUN;
        HZ_MEM_WAIT: r_state <= dmem_busy ? HZ_MEM_WAIT : HZ_RUN;
        default:     r_state <= HZ_RUN;
      endcase
    end
  end

  // A branch resolved while memory is stalled is parked here until the
  // pipe releases; a later branch during the same stall replaces it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else if (dmem_busy && branch_taken_ex) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= target_ex;
    end else if (w_exit) begin
      r_pend_valid  <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_hold) begin
        r_stall_cycles <= hz_sat_inc_32(r_stall_cycles);
      end
      if (w_redirect) begin
        r_flush_count <= hz_sat_inc_16(r_flush_count);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id, mem_read_ex;
  logic        branch_taken_ex, dmem_busy;
  logic [31:0] target_ex;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        bubble_id_ex, bubble_mem_wb, flush_if_id, pc_redirect;
  logic [31:0] pc_target, stall_cycles;
  logic [15:0] flush_count;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .branch_taken_ex (branch_taken_ex),
    .target_ex       (target_ex),
    .dmem_busy       (dmem_busy),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .stall_id_ex     (stall_id_ex),
    .stall_ex_mem    (stall_ex_mem),
    .bubble_id_ex    (bubble_id_ex),
    .bubble_mem_wb   (bubble_mem_wb),
    .flush_if_id     (flush_if_id),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  typedef struct {
    string       tag;
    logic [7:0]  ctl;      // stall_pc,stall_if_id,stall_id_ex,stall_ex_mem,bubble_id_ex,bubble_mem_wb,flush_if_id,pc_redirect
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [31:0] scyc;
    logic [15:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: whether the pipe was held last cycle, the parked redirect, counters.
  bit          m_was_busy = 0;
  bit          m_pend_v   = 0;
  logic [31:0] m_pend_t   = 0;
  longint      m_scyc     = 0;
  longint      m_fcnt     = 0;

  task automatic step(input string tag, input bit rst_low,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic br,
                      input logic [31:0] tg, input logic busy);
    exp_t e;
    bit lu, redir, hazard_stall;
    @(posedge clk);
    #1;
    rstn = !rst_low;
    rs1_id = r1; rs1_used_id = u1; rs2_id = r2; rs2_used_id = u2;
    rd_ex = rd; mem_read_ex = mr; branch_taken_ex = br; target_ex = tg; dmem_busy = busy;
    e.tag = tag;
`ifdef HAZARD_PERF_EN
    e.scyc = rst_low ? 32'd0 : m_scyc[31:0];
    e.fcnt = rst_low ? 16'd0 : m_fcnt[15:0];
`else
    e.scyc = 32'd0;
    e.fcnt = 16'd0;
`endif
    if (rst_low) begin
      e.ctl = 8'd0; e.chk_tgt = 1'b1; e.tgt = 32'd0;
      m_was_busy = 0; m_pend_v = 0; m_pend_t = 0; m_scyc = 0; m_fcnt = 0;
    end else begin
      lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      e.chk_tgt = 1'b0; e.tgt = 32'd0;
      if (busy) begin
        e.ctl = 8'b1111_0100;
        if (br) begin m_pend_v = 1; m_pend_t = tg; end
        if (m_scyc < 64'hFFFF_FFFF) m_scyc++;
      end else begin
        redir = br || (m_was_busy && m_pend_v);
        hazard_stall = lu && !redir;
        e.ctl = {hazard_stall, hazard_stall, 1'b0, 1'b0, redir || hazard_stall, 1'b0, redir, redir};
        if (redir) begin
          e.chk_tgt = 1'b1;
          e.tgt = (m_was_busy && m_pend_v) ? m_pend_t : tg;
          if (m_fcnt < 64'hFFFF) m_fcnt++;
        end
        m_pend_v = 0;
      end
      m_was_busy = busy;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag, input logic busy);
    step(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'd0, busy);
  endtask

  // Monitor: samples mid-cycle, well away from the rising edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               bubble_id_ex, bubble_mem_wb, flush_if_id, pc_redirect};
        n_cmp++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b want %b", e.tag, act, e.ctl);
        end
        if (e.chk_tgt) begin
          n_cmp++;
          if (pc_target !== e.tgt) begin
            n_fail++;
            $display("FAIL %s pc_target: got %h want %h", e.tag, pc_target, e.tgt);
          end
        end
        n_cmp++;
        if (stall_cycles !== e.scyc || flush_count !== e.fcnt) begin
          n_fail++;
          $display("FAIL %s counters: got %0d/%0d want %0d/%0d",
                   e.tag, stall_cycles, flush_count, e.scyc, e.fcnt);
        end
      end
    end
  end

  initial begin
    logic [4:0] a, b, d;
    rstn = 0; rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
    rd_ex = 0; mem_read_ex = 0; branch_taken_ex = 0; target_ex = 0; dmem_busy = 0;

    // Reset with active inputs: everything must read zero.
    step("reset", 1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 32'h1234, 1);
    step("reset2", 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 32'h0, 0);
    idle("post_reset", 0);

    // Load-use on rs1, then with rd=0, then on rs2.
    step("lu_rs1", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 32'h0, 0);
    idle("lu_after", 0);
    step("lu_rd0", 0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 32'h0, 0);
    step("lu_rs2", 0, 5'd1, 1, 5'd7, 1, 5'd7, 1, 0, 32'h0, 0);
    step("lu_unused", 0, 5'd7, 0, 5'd7, 0, 5'd7, 1, 0, 32'h0, 0);

    // Branch alone, and branch together with load-use.
    step("br", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h0000_1040, 0);
    step("br_lu", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 32'h0000_1040, 0);

    // Three busy cycles with load-use present; then release.
    step("busy1", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 32'h0, 1);
    idle("busy2", 1);
    idle("busy3", 1);
    idle("busy_exit", 0);

    // Branches in the 2nd and 3rd busy cycles: last target wins on exit.
    idle("pend_b1", 1);
    step("pend_b2", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h0000_2000, 1);
    step("pend_b3", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h0000_3000, 1);
    step("pend_exit", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 32'h0, 0);
    idle("pend_after", 0);

    // Single busy cycle.
    idle("busy_single", 1);
    idle("busy_single_exit", 0);

    // Reset during MEM_WAIT with a parked redirect: it must be dropped.
    idle("rst_pend_b1", 1);
    step("rst_pend_b2", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h0000_4000, 1);
    step("rst_pend_rst", 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'h0, 1);
    idle("rst_pend_rel", 0);
    idle("rst_pend_rel2", 0);

    // Random traffic over a small register space to hit dependencies often.
    for (int i = 0; i < 400; i++) begin
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      step("rand", ($urandom_range(0, 99) == 0),
           a, 1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
           d, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           $urandom, ($urandom_range(0, 2) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
